ads1115_responder: RTL

- Synthesizable I2C target that emulates the ADS1115 register interface at the far end of the bus driven by our ADS1115 command sequencer and I2C engine.
- Replaces the real converter in simulation and on-board loopback, so the master side can be checked without the chip.
- Decodes START/STOP, address, pointer and data bytes from oversampled SCL/SDA.
- Holds the config, lo_thresh, hi_thresh and conversion registers, and returns 16-bit register contents on reads.

---
 rtl/ads1115_pkg.sv | 42 ++++
 rtl/ads1115_responder_bus_monitor.sv | 59 +++++
 rtl/ads1115_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads1115_pkg.sv
// ads1115_pkg
// Shared definitions for the ADS1115 register-interface responder:
// register pointer codes, register reset values, the responder FSM
// state encoding, the default bus address and the config read view.
package ads1115_pkg;

    // Register pointer codes, as carried in the low two bits of the pointer byte
    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    // Register reset values
    localparam logic [15:0] CFG_RST  = 16'h8583;
    localparam logic [15:0] LO_RST   = 16'h8000;
    localparam logic [15:0] HI_RST   = 16'h7FFF;
    localparam logic [15:0] CONV_RST = 16'h0000;

    // Default 7-bit target address
    localparam logic [6:0] DEF_DEV_ADDR = 7'h48;

    // Responder FSM states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_BYTE   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_BYTE   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } resp_state_t;

    // Config as seen from outside: OS (bit 15) reads 0 while a conversion
    // is running and 1 otherwise; every other bit is the stored value.
    function automatic logic [15:0] cfg_view(input logic [15:0] cfg, input logic busy);
        return {~busy, cfg[14:0]};
    endfunction

endpackage

// File: rtl/ads1115_responder_bus_monitor.sv
// i2c_bus_monitor
// Synchronizes the raw SCL/SDA levels and produces single-cycle event
// pulses for SCL edges and for START/STOP conditions.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   scl_i, sda_i        raw bus levels
//   sda                 synchronized SDA level
//   scl_rise, scl_fall  one-cycle pulses on synchronized SCL edges
//   start_det           SDA fell while SCL stayed high
//   stop_det            SDA rose while SCL stayed high
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Anything below two stages is not a real synchronizer, so clamp it.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync;
    logic [STAGES-1:0] sda_sync;
    logic              scl_s;
    logic              scl_prev;
    logic              sda_prev;

    // Synchronizer chains plus one history flop per line for edge detection.
    // Everything resets to the idle-bus level (high) so that leaving reset
    // on an idle bus produces no spurious edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[STAGES-2:0], sda_i};
            scl_prev <= scl_sync[STAGES-1];
            sda_prev <= sda_sync[STAGES-1];
        end
    end

    assign scl_s     = scl_sync[STAGES-1];
    assign sda       = sda_sync[STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    // SCL must be high on both sides of the SDA transition
    assign start_det = scl_s & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/ads1115_responder.sv
// ads1115_responder
// I2C target emulating the ADS1115 register interface. Holds the
// conversion, config, lo_thresh and hi_thresh registers, accepts pointer
// and 16-bit register writes, returns 16-bit words on reads, and models
// conversion timing with a cycle counter that latches sample_in.
// Ports:
//   clk, rst_n   system clock (>= 8x SCL), asynchronous active-low reset
//   scl_i, sda_i bus levels
//   sda_oe       1 = pull SDA low, 0 = release (open drain)
//   sample_in    analog value captured at end of conversion
//   cfg_out      config register with the live OS bit
//   conv_done    one-cycle pulse when the conversion register updates
//   busy         conversion in progress
module ads1115_responder
    import ads1115_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
    parameter int         CONV_CYCLES = 1000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] sample_in,
    output logic [15:0] cfg_out,
    output logic        conv_done,
    output logic        busy
);

    localparam int          CW        = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_monitor (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    resp_state_t   state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_in;
    logic [15:0]   shift_out;
    logic          rw;
    logic          ack_bit;
    logic [7:0]    hi_byte;
    logic          hi_pending;
    logic          lsb_phase;
    logic [1:0]    pointer;

    logic          wr_en;
    logic [1:0]    wr_ptr;
    logic [15:0]   wr_data;

    logic [15:0]   cfg_reg;
    logic [15:0]   lo_reg;
    logic [15:0]   hi_reg;
    logic [15:0]   conv_reg;
    logic [CW-1:0] conv_cnt;
    logic [15:0]   rd_word;

    // Word presented for a read snapshot. Because conversion results land
    // through a register, a snapshot taken on the latch cycle sees the old
    // value.
    always_comb begin
        rd_word = conv_reg;
        case (pointer)
            PTR_CONV: rd_word = conv_reg;
            PTR_CFG:  rd_word = cfg_view(cfg_reg, busy);
            PTR_LO:   rd_word = lo_reg;
            default:  rd_word = hi_reg;
        endcase
    end

    // Bus protocol FSM. Bits are sampled on SCL rise; every change of
    // sda_oe is made on an SCL fall so it lands while SCL is low. START and
    // STOP override whatever the FSM was doing. A completed 16-bit write is
    // handed to the register block as a one-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift_in   <= 8'h00;
            shift_out  <= 16'h0000;
            rw         <= 1'b0;
            ack_bit    <= 1'b1;
            hi_byte    <= 8'h00;
            hi_pending <= 1'b0;
            lsb_phase  <= 1'b0;
            pointer    <= PTR_CONV;
            sda_oe     <= 1'b0;
            wr_en      <= 1'b0;
            wr_ptr     <= PTR_CONV;
            wr_data    <= 16'h0000;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shift_in <= {shift_in[6:0], sda};
                    ack_bit  <= sda;
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                if (scl_fall) begin
                    case (state)
                        ST_ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                if (shift_in[7:1] == DEV_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    rw     <= shift_in[0];
                                end else begin
                                    state  <= ST_WAIT_STOP;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                        ST_ADDR_ACK: begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state     <= ST_RD_BYTE;
                                shift_out <= rd_word;
                                sda_oe    <= ~rd_word[15];
                                lsb_phase <= 1'b0;
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                        ST_PTR: begin
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_PTR_ACK;
                                sda_oe  <= 1'b1;
                                pointer <= shift_in[1:0];
                            end
                        end
                        ST_PTR_ACK: begin
                            state      <= ST_WR_BYTE;
                            sda_oe     <= 1'b0;
                            bit_cnt    <= 4'd0;
                            hi_pending <= 1'b0;
                        end
                        ST_WR_BYTE: begin
                            if (bit_cnt == 4'd8) begin
                                state  <= ST_WR_ACK;
                                sda_oe <= 1'b1;
                                if (!hi_pending) begin
                                    hi_byte    <= shift_in;
                                    hi_pending <= 1'b1;
                                end else begin
                                    hi_pending <= 1'b0;
                                    // The conversion register is read-only
                                    if (pointer != PTR_CONV) begin
                                        wr_en   <= 1'b1;
                                        wr_ptr  <= pointer;
                                        wr_data <= {hi_byte, shift_in};
                                    end
                                end
                            end
                        end
                        ST_WR_ACK: begin
                            state   <= ST_WR_BYTE;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                        ST_RD_BYTE: begin
                            // Shift on every fall so shift_out[15] is always
                            // the bit to be driven next.
                            shift_out <= {shift_out[14:0], 1'b0};
                            if (bit_cnt == 4'd8) begin
                                state  <= ST_RD_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                sda_oe <= ~shift_out[14];
                            end
                        end
                        ST_RD_ACK: begin
                            bit_cnt <= 4'd0;
                            if (ack_bit) begin
                                state  <= ST_WAIT_STOP;
                                sda_oe <= 1'b0;
                            end else if (!lsb_phase) begin
                                state     <= ST_RD_BYTE;
                                lsb_phase <= 1'b1;
                                sda_oe    <= ~shift_out[15];
                            end else begin
                                state     <= ST_RD_BYTE;
                                lsb_phase <= 1'b0;
                                shift_out <= rd_word;
                                sda_oe    <= ~rd_word[15];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Register file and conversion timer. A config commit with OS set, or
    // any config commit in continuous mode (bit 8 = 0), (re)starts the
    // counter; the commit wins over a completion on the same cycle. At
    // zero the sample is latched; single-shot stops, continuous reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg   <= CFG_RST;
            lo_reg    <= LO_RST;
            hi_reg    <= HI_RST;
            conv_reg  <= CONV_RST;
            conv_cnt  <= '0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            if (busy) begin
                if (conv_cnt == '0) begin
                    conv_reg  <= sample_in;
                    conv_done <= 1'b1;
                    if (cfg_reg[8]) begin
                        busy <= 1'b0;
                    end else begin
                        conv_cnt <= CNT_LOAD;
                    end
                end else begin
                    conv_cnt <= conv_cnt - CW'(1);
                end
            end
            if (wr_en) begin
                case (wr_ptr)
                    PTR_CFG: begin
                        cfg_reg <= wr_data;
                        if (wr_data[15] || !wr_data[8]) begin
                            busy     <= 1'b1;
                            conv_cnt <= CNT_LOAD;
                        end
                    end
                    PTR_LO:  lo_reg <= wr_data;
                    PTR_HI:  hi_reg <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    assign cfg_out = cfg_view(cfg_reg, busy);

endmodule
